ret_sequencer: RTL and testbench

Sequential microcode engine for the return family of instructions: RET, RETI, and conditional RET cc. It is the pop-side counterpart of the CALL push sequence. It owns its own M-cycle and T-step counters, reads the return address from the stack into W/Z, advances SP, loads PC, and then hands control back to instruction fetch. It sits in the Control Unit beside the other instruction microcode blocks, and its outputs are ORed into the shared register-file and bus control lines.

---
 rtl/ret_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_ret_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ret_sequencer.sv
// ret_sequencer: microcode engine for RET, RETI and RET cc.
// Pops the return address into Z (low byte) then W (high byte), advancing SP by
// +1 after each pop. It then loads PC from WZ, optionally pulses IME for RETI,
// and runs one opcode-fetch M-cycle before returning to idle.
//
// Ports:
//   i_Clk          rising-edge clock
//   i_Reset        synchronous active-high reset
//   i_Start        decoder pulse, sampled only while idle
//   i_Conditional  1 = RET cc, 0 = RET / RETI (captured with i_Start)
//   i_Reti         1 = RETI (captured with i_Start)
//   i_Y            one-hot condition select NZ/Z/NC/C (captured with i_Start)
//   i_Conditions   live condition vector, sampled only at COND T3
//   o_Busy         sequence in progress
//   o_IR_Fetch     opcode-fetch M-cycle
//   o_Write8       8-bit register write, bit1 = Z, bit0 = W
//   o_Read16       16-bit source, bit5 = PC, bit4 = SP, bit0 = WZ
//   o_Write16      16-bit destination, same encoding as o_Read16
//   o_Bus_In       data bus feeds the 8-bit write path
//   o_Address_Out  selected 16-bit register drives the address bus
//   o_Increment16  00 = pass, 01 = +1
//   o_Set_IME      one-clock IME set pulse (RETI only)
//   o_Done         one-clock pulse on the final T-step
// All outputs are registered and are all-zero while idle, so they can be
// OR-merged with the other microcode blocks.
module ret_sequencer (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Start,
  input  logic       i_Conditional,
  input  logic       i_Reti,
  input  logic [3:0] i_Y,
  input  logic [3:0] i_Conditions,
  output logic       o_Busy,
  output logic       o_IR_Fetch,
  output logic [7:0] o_Write8,
  output logic [5:0] o_Read16,
  output logic [5:0] o_Write16,
  output logic       o_Bus_In,
  output logic       o_Address_Out,
  output logic [1:0] o_Increment16,
  output logic       o_Set_IME,
  output logic       o_Done
);

  localparam int unsigned STEP_W = 2;
  localparam int unsigned COND_W = 4;
  localparam int unsigned W8_W   = 8;
  localparam int unsigned R16_W  = 6;
  localparam int unsigned INC_W  = 2;

  localparam logic [STEP_W-1:0] STEP_T0   = STEP_W'(0);
  localparam logic [STEP_W-1:0] STEP_T1   = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(3);

  localparam logic [R16_W-1:0] SEL_NONE = R16_W'(0);
  localparam logic [R16_W-1:0] SEL_PC   = R16_W'(6'b100000);
  localparam logic [R16_W-1:0] SEL_SP   = R16_W'(6'b010000);
  localparam logic [R16_W-1:0] SEL_WZ   = R16_W'(6'b000001);

  localparam logic [W8_W-1:0] WR_NONE = W8_W'(0);
  localparam logic [W8_W-1:0] WR_Z    = W8_W'(8'b0000_0010);
  localparam logic [W8_W-1:0] WR_W    = W8_W'(8'b0000_0001);

  localparam logic [INC_W-1:0] INC_PASS = INC_W'(2'b00);
  localparam logic [INC_W-1:0] INC_PLUS = INC_W'(2'b01);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COND,
    ST_POP_LO,
    ST_POP_HI,
    ST_SET_PC,
    ST_FETCH
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [STEP_W-1:0]   step;
  logic [STEP_W-1:0]   step_n;
  logic [COND_W-1:0]   y_q;
  logic                reti_q;
  logic                cond_q;
  logic                taken_c;

  // Next-cycle output values, registered below so outputs are pure Moore.
  logic                busy_n;
  logic                ir_fetch_n;
  logic [W8_W-1:0]     write8_n;
  logic [R16_W-1:0]    read16_n;
  logic [R16_W-1:0]    write16_n;
  logic                bus_in_n;
  logic                address_out_n;
  logic [INC_W-1:0]    increment16_n;
  logic                set_ime_n;
  logic                done_n;

  // Condition test; an unconditional capture always counts as taken.
  assign taken_c = !cond_q || (|(y_q & i_Conditions));

  // Next state and T-step: step runs T0..T3, state advances only on T3.
  always_comb begin
    state_n = state;
    step_n  = step;
    case (state)
      ST_IDLE: begin
        step_n = STEP_T0;
        if (i_Start) begin
          state_n = i_Conditional ? ST_COND : ST_POP_LO;
        end
      end
      default: begin
        step_n = STEP_W'(step + STEP_W'(1));
        if (step == STEP_LAST) begin
          case (state)
            ST_COND:   state_n = taken_c ? ST_POP_LO : ST_FETCH;
            ST_POP_LO: state_n = ST_POP_HI;
            ST_POP_HI: state_n = ST_SET_PC;
            ST_SET_PC: state_n = ST_FETCH;
            default:   state_n = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  // Output decode of the upcoming state/step.
  always_comb begin
    busy_n        = (state_n != ST_IDLE);
    ir_fetch_n    = 1'b0;
    write8_n      = WR_NONE;
    read16_n      = SEL_NONE;
    write16_n     = SEL_NONE;
    bus_in_n      = 1'b0;
    address_out_n = 1'b0;
    increment16_n = INC_PASS;
    set_ime_n     = 1'b0;
    done_n        = 1'b0;
    case (state_n)
      ST_POP_LO, ST_POP_HI: begin
        if (step_n == STEP_T0) begin
          // Memory read at SP into Z (first pop) or W (second pop).
          read16_n      = SEL_SP;
          address_out_n = 1'b1;
          bus_in_n      = 1'b1;
          write8_n      = (state_n == ST_POP_LO) ? WR_Z : WR_W;
        end else if (step_n == STEP_T1) begin
          read16_n      = SEL_SP;
          write16_n     = SEL_SP;
          increment16_n = INC_PLUS;
        end
      end
      ST_SET_PC: begin
        if (step_n == STEP_T1) begin
          read16_n      = SEL_WZ;
          write16_n     = SEL_PC;
          increment16_n = INC_PASS;
          set_ime_n     = reti_q;
        end
      end
      ST_FETCH: begin
        ir_fetch_n = 1'b1;
        done_n     = (step_n == STEP_LAST);
      end
      default: ;
    endcase
  end

  // State, captured opcode fields and registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state         <= ST_IDLE;
      step          <= STEP_T0;
      y_q           <= COND_W'(0);
      reti_q        <= 1'b0;
      cond_q        <= 1'b0;
      o_Busy        <= 1'b0;
      o_IR_Fetch    <= 1'b0;
      o_Write8      <= WR_NONE;
      o_Read16      <= SEL_NONE;
      o_Write16     <= SEL_NONE;
      o_Bus_In      <= 1'b0;
      o_Address_Out <= 1'b0;
      o_Increment16 <= INC_PASS;
      o_Set_IME     <= 1'b0;
      o_Done        <= 1'b0;
    end else begin
      state <= state_n;
      step  <= step_n;
      // Opcode fields are frozen for the whole sequence.
      if (state == ST_IDLE && i_Start) begin
        y_q    <= i_Y;
        reti_q <= i_Reti;
        cond_q <= i_Conditional;
      end
      o_Busy        <= busy_n;
      o_IR_Fetch    <= ir_fetch_n;
      o_Write8      <= write8_n;
      o_Read16      <= read16_n;
      o_Write16     <= write16_n;
      o_Bus_In      <= bus_in_n;
      o_Address_Out <= address_out_n;
      o_Increment16 <= increment16_n;
      o_Set_IME     <= set_ime_n;
      o_Done        <= done_n;
    end
  end

endmodule

// File: tb/tb_ret_sequencer.sv
// tb_ret_sequencer: drives ret_sequencer with directed RET-family sequences
// and random traffic. A plan-based model predicts every output each cycle,
// and a small CPU datapath (SP, W, Z, PC, memory) follows the DUT controls so
// the stack pop results can be pinned with literal values.
module tb_ret_sequencer;

  localparam int K_COND  = 0;
  localparam int K_LO    = 1;
  localparam int K_HI    = 2;
  localparam int K_PC    = 3;
  localparam int K_FETCH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cond = 1'b0;
  logic       reti = 1'b0;
  logic [3:0] y = 4'd0;
  logic [3:0] conds = 4'd0;

  logic       busy, ir_fetch, bus_in, addr_out, set_ime, done;
  logic [7:0] write8;
  logic [5:0] read16, write16;
  logic [1:0] inc16;

  ret_sequencer dut (
    .i_Clk(clk), .i_Reset(rst), .i_Start(start), .i_Conditional(cond),
    .i_Reti(reti), .i_Y(y), .i_Conditions(conds),
    .o_Busy(busy), .o_IR_Fetch(ir_fetch), .o_Write8(write8),
    .o_Read16(read16), .o_Write16(write16), .o_Bus_In(bus_in),
    .o_Address_Out(addr_out), .o_Increment16(inc16),
    .o_Set_IME(set_ime), .o_Done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state: list of M-cycle kinds and current clock within the sequence.
  bit         m_active = 1'b0;
  int         m_k = 0;
  int         m_nmc = 0;
  int         plan [5];
  bit         m_reti = 1'b0;
  logic [3:0] m_y = 4'd0;
  logic [27:0] exp_v = '0;

  // Emulated datapath.
  logic [7:0]  mem [0:65535];
  logic [15:0] sp = 16'd0;
  logic [15:0] pc = 16'd0;
  logic [7:0]  w = 8'd0;
  logic [7:0]  z = 8'd0;

  // Per-sequence observations.
  int done_rel, zl_rel, wl_rel, pcw_rel, ime_rel, ime_cnt, inc_cnt;
  int addr_cnt, rd_cnt, ir_first, ir_last;
  logic rst_busy;
  logic [27:0] rst_out;

  function automatic logic [27:0] pack_dut();
    return {busy, ir_fetch, write8, read16, write16, bus_in, addr_out, inc16, set_ime, done};
  endfunction

  // Expected outputs for one clock of an M-cycle of the given kind.
  function automatic logic [27:0] expect_out(input bit act, input int kind, input int t, input bit r);
    logic       e_busy, e_ir, e_bus, e_addr, e_ime, e_done;
    logic [7:0] e_w8;
    logic [5:0] e_r16, e_w16;
    logic [1:0] e_inc;
    e_busy = act; e_ir = 0; e_bus = 0; e_addr = 0; e_ime = 0; e_done = 0;
    e_w8 = 8'd0; e_r16 = 6'd0; e_w16 = 6'd0; e_inc = 2'd0;
    if (act) begin
      if ((kind == K_LO || kind == K_HI) && t == 0) begin
        e_r16 = 6'b010000; e_addr = 1; e_bus = 1;
        e_w8 = (kind == K_LO) ? 8'h02 : 8'h01;
      end
      if ((kind == K_LO || kind == K_HI) && t == 1) begin
        e_r16 = 6'b010000; e_w16 = 6'b010000; e_inc = 2'b01;
      end
      if (kind == K_PC && t == 1) begin
        e_r16 = 6'b000001; e_w16 = 6'b100000; e_ime = r;
      end
      if (kind == K_FETCH) begin
        e_ir = 1; e_done = (t == 3);
      end
    end
    return {e_busy, e_ir, e_w8, e_r16, e_w16, e_bus, e_addr, e_inc, e_ime, e_done};
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  // One directed sequence; event offsets are clocks after the start clock N.
  task automatic run_seq(input bit c, input bit r, input logic [3:0] yy, input logic [3:0] cc,
                         input int glitch_at, input int restart_at, input int reset_at);
    @(posedge clk); #1;
    rst = 0; start = 1; cond = c; reti = r; y = yy; conds = cc;
    @(posedge clk); #1;
    start = 0;
    done_rel = -1; zl_rel = -1; wl_rel = -1; pcw_rel = -1; ime_rel = -1;
    ime_cnt = 0; inc_cnt = 0; addr_cnt = 0; rd_cnt = 0; ir_first = -1; ir_last = -1;
    for (int rel = 1; rel <= 30; rel++) begin
      @(negedge clk);
      if (inc16 == 2'b01) inc_cnt++;
      if (set_ime) begin ime_cnt++; ime_rel = rel; end
      if (write16 == 6'b100000) pcw_rel = rel;
      if (addr_out) addr_cnt++;
      if (read16 != 6'd0) rd_cnt++;
      if (ir_fetch) begin if (ir_first < 0) ir_first = rel; ir_last = rel; end
      if (bus_in && write8[1]) zl_rel = rel;
      if (bus_in && write8[0]) wl_rel = rel;
      if (done) begin done_rel = rel; break; end
      if (rel == reset_at + 1) begin
        rst_busy = busy; rst_out = pack_dut(); rst = 0; break;
      end
      if (rel == reset_at) rst = 1;
      if (rel == glitch_at) conds = 4'b0000;
      if (rel == glitch_at + 1) conds = cc;
      if (rel == restart_at) begin start = 1; reti = 1; end
      if (rel == restart_at + 1) begin start = 0; reti = 0; end
    end
  endtask

  initial begin
    fork
      // Reference model: plan of M-cycles, decided at COND T3 for RET cc.
      forever begin
        @(posedge clk);
        if (rst) begin
          m_active = 0;
        end else if (!m_active) begin
          if (start) begin
            m_active = 1; m_k = 1; m_reti = reti; m_y = y;
            if (cond) begin
              plan[0] = K_COND; m_nmc = 1;
            end else begin
              plan[0] = K_LO; plan[1] = K_HI; plan[2] = K_PC; plan[3] = K_FETCH; m_nmc = 4;
            end
          end
        end else begin
          if (plan[0] == K_COND && m_k == 4 && m_nmc == 1) begin
            if (|(m_y & conds)) begin
              plan[1] = K_LO; plan[2] = K_HI; plan[3] = K_PC; plan[4] = K_FETCH; m_nmc = 5;
            end else begin
              plan[1] = K_FETCH; m_nmc = 2;
            end
          end
          if (m_k == 4 * m_nmc) m_active = 0;
          else m_k++;
        end
        exp_v = m_active ? expect_out(1'b1, plan[(m_k - 1) / 4], (m_k - 1) % 4, m_reti)
                         : expect_out(1'b0, 0, 0, 1'b0);
      end
      // Datapath that obeys the DUT control lines.
      forever begin
        @(posedge clk);
        if (addr_out && bus_in && read16 == 6'b010000) begin
          if (write8[1]) z = mem[sp];
          if (write8[0]) w = mem[sp];
        end
        if (write16 == 6'b010000 && inc16 == 2'b01) sp = sp + 16'd1;
        if (write16 == 6'b100000 && read16 == 6'b000001) pc = {w, z};
      end
      // Every-cycle comparison against the model.
      forever begin
        @(negedge clk);
        if (cmp_en) begin
          checks++;
          if (pack_dut() !== exp_v) begin
            errors++;
            $display("FAIL cycle_compare t=%0t actual=%07h expected=%07h", $time, pack_dut(), exp_v);
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 0;
    cmp_en = 1;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_outputs", int'(pack_dut()), 0);

    // Plain RET from 0xFFFC.
    mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12; sp = 16'hFFFC;
    run_seq(0, 0, 4'b0000, 4'b0000, -10, -10, -10);
    chk("ret_done_rel", done_rel, 16);
    chk("ret_z_load_rel", zl_rel, 1);
    chk("ret_w_load_rel", wl_rel, 5);
    chk("ret_z", int'(z), 'h34);
    chk("ret_w", int'(w), 'h12);
    chk("ret_sp", int'(sp), 'hFFFE);
    chk("ret_pc", int'(pc), 'h1234);
    chk("ret_pc_write_rel", pcw_rel, 10);
    chk("ret_fetch_first", ir_first, 13);
    chk("ret_fetch_last", ir_last, 16);
    chk("ret_inc_count", inc_cnt, 2);
    chk("ret_ime_count", ime_cnt, 0);

    // RET NZ, not taken.
    run_seq(1, 0, 4'b0001, 4'b0010, -10, -10, -10);
    chk("nz_done_rel", done_rel, 8);
    chk("nz_addr_count", addr_cnt, 0);
    chk("nz_read16_count", rd_cnt, 0);
    chk("nz_fetch_first", ir_first, 5);
    chk("nz_fetch_last", ir_last, 8);
    chk("nz_sp", int'(sp), 'hFFFE);

    // RET Z, taken, condition glitches low at N+2 only.
    mem[16'h1000] = 8'h78; mem[16'h1001] = 8'h56; sp = 16'h1000;
    run_seq(1, 0, 4'b0010, 4'b0010, 2, -10, -10);
    chk("z_done_rel", done_rel, 20);
    chk("z_pc", int'(pc), 'h5678);
    chk("z_sp", int'(sp), 'h1002);

    // RETI.
    sp = 16'hFFFC;
    run_seq(0, 1, 4'b0000, 4'b0000, -10, -10, -10);
    chk("reti_done_rel", done_rel, 16);
    chk("reti_ime_count", ime_cnt, 1);
    chk("reti_ime_rel", ime_rel, 10);
    chk("reti_pc_write_rel", pcw_rel, 10);
    chk("reti_pc", int'(pc), 'h1234);

    // Reset inside POP_HI, then a fresh RET at N+8.
    pc = 16'd0; sp = 16'hFFFC;
    run_seq(0, 0, 4'b0000, 4'b0000, -10, -10, 6);
    chk("abort_busy", int'(rst_busy), 0);
    chk("abort_outputs", int'(rst_out), 0);
    chk("abort_no_done", done_rel, -1);
    chk("abort_pc_untouched", int'(pc), 0);
    sp = 16'hFFFC;
    run_seq(0, 0, 4'b0000, 4'b0000, -10, -10, -10);
    chk("fresh_done_rel", done_rel, 16);
    chk("fresh_pc", int'(pc), 'h1234);

    // Start re-pulsed with RETI at N+3 is ignored; next start at N+17 is taken.
    sp = 16'hFFFC;
    run_seq(0, 0, 4'b0000, 4'b0000, -10, 3, -10);
    chk("restart_done_rel", done_rel, 16);
    chk("restart_ime_count", ime_cnt, 0);
    mem[16'hFFFF] = 8'hCD; mem[16'h0000] = 8'hAB; sp = 16'hFFFF;
    run_seq(0, 0, 4'b0000, 4'b0000, -10, -10, -10);
    chk("b2b_done_rel", done_rel, 16);
    chk("wrap_pc", int'(pc), 'hABCD);
    chk("wrap_sp", int'(sp), 'h0001);

    // Random traffic, including busy-time starts and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst   = ($urandom_range(0, 149) == 0);
      start = ($urandom_range(0, 3) == 0);
      cond  = 1'($urandom_range(0, 1));
      reti  = 1'($urandom_range(0, 1));
      y     = 4'($urandom);
      conds = 4'($urandom);
    end
    @(posedge clk); #1;
    rst = 1; start = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("final_idle_busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
